// File: rtl/axil_log_packer.sv
// Packs AXI-Lite recorder log bodies and log-end bitmaps into 64-bit stream
// packets: one header beat followed by zero to two payload beats.
module axil_log_packer #(
  parameter int AW_WIDTH = 32,
  parameter int W_WIDTH  = 36,
  parameter int AR_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [2:0]                            logb_valid,
  input  logic [AW_WIDTH+W_WIDTH+AR_WIDTH-1:0]  logb_data,
  input  logic [4:0]                            loge_valid,
  output logic                                  ready,
  output logic                                  out_valid,
  output logic [63:0]                           out_data,
  output logic                                  out_last,
  input  logic                                  out_ready,
  output logic [31:0]                           pkt_cnt
);

  localparam int TOT_W = AW_WIDTH + W_WIDTH + AR_WIDTH;

  typedef enum logic [1:0] {IDLE, HDR, PAY0, PAY1} state_e;

  state_e       state_q, state_d;
  logic [2:0]   logb_q;
  logic [4:0]   loge_q;
  logic [1:0]   beats_q;
  logic [127:0] pay_q;
  logic [31:0]  cnt_q;

  logic         accept;
  logic         beat_hs;
  logic         last_hs;

  // Present bodies are packed back to back from bit 0 in AW, W, AR order.
  function automatic logic [127:0] pack_body(input logic [2:0] v,
                                             input logic [TOT_W-1:0] d);
    logic [127:0] acc;
    logic [7:0]   off;
    acc = '0;
    off = '0;
    if (v[0]) begin
      acc = acc | (128'(d[AW_WIDTH-1:0]) << off);
      off = off + 8'(AW_WIDTH);
    end
    if (v[1]) begin
      acc = acc | (128'(d[AW_WIDTH+W_WIDTH-1:AW_WIDTH]) << off);
      off = off + 8'(W_WIDTH);
    end
    if (v[2]) begin
      acc = acc | (128'(d[TOT_W-1:AW_WIDTH+W_WIDTH]) << off);
    end
    return acc;
  endfunction

  function automatic logic [1:0] beat_count(input logic [2:0] v);
    logic [7:0] bits;
    bits = (v[0] ? 8'(AW_WIDTH) : 8'd0) +
           (v[1] ? 8'(W_WIDTH)  : 8'd0) +
           (v[2] ? 8'(AR_WIDTH) : 8'd0);
    return 2'((bits + 8'd63) >> 6);
  endfunction

  assign beat_hs = out_valid && out_ready;
  assign last_hs = beat_hs && out_last;
  assign ready   = rstn && ((state_q == IDLE) || last_hs);
  assign accept  = ready && ((|logb_valid) || (|loge_valid));

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = HDR;
      end
      HDR: begin
        out_valid = 1'b1;
        out_last  = (beats_q == 2'd0);
        out_data  = {48'd0, 6'd0, beats_q, loge_q, logb_q};
        if (beat_hs && beats_q != 2'd0) state_d = PAY0;
      end
      PAY0: begin
        out_valid = 1'b1;
        out_last  = (beats_q != 2'd2);
        out_data  = pay_q[63:0];
        if (beat_hs && beats_q == 2'd2) state_d = PAY1;
      end
      PAY1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = pay_q[127:64];
      end
      default: state_d = IDLE;
    endcase
    // Packet end: chain straight into the next header when a new log is taken.
    if (state_q != IDLE && last_hs) state_d = accept ? HDR : IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      logb_q  <= '0;
      loge_q  <= '0;
      beats_q <= '0;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        logb_q  <= logb_valid;
        loge_q  <= loge_valid;
        beats_q <= beat_count(logb_valid);
        pay_q   <= pack_body(logb_valid, logb_data);
      end
      if (last_hs) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = cnt_q;

endmodule

// File: tb/tb_axil_log_packer.sv
// Directed bench for axil_log_packer: header/payload packing, backpressure,
// back-to-back packets and mid-packet reset.
module tb_axil_log_packer;

  logic         clk;
  logic         rstn;
  logic [2:0]   logb_valid;
  logic [99:0]  logb_data;
  logic [4:0]   loge_valid;
  logic         ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_last;
  logic         out_ready;
  logic [31:0]  pkt_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_cnt = 32'd0;

  axil_log_packer dut (
    .clk        (clk),
    .rstn       (rstn),
    .logb_valid (logb_valid),
    .logb_data  (logb_data),
    .loge_valid (loge_valid),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] lb, input logic [31:0] aw,
                       input logic [35:0] w, input logic [31:0] ar,
                       input logic [4:0] le);
    logb_valid = lb;
    logb_data  = {ar, w, aw};
    loge_valid = le;
  endtask

  task automatic idle_inputs();
    logb_valid = 3'b000;
    loge_valid = 5'b00000;
    logb_data  = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    step();
    step();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_cmp++; if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    rstn = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
    exp_cnt = 32'd0;
  endtask

  task automatic test_aw_only();
    out_ready = 1'b1;
    drive(3'b001, 32'h1234, 36'h0, 32'h0, 5'b00001);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL aw_ready_idle: got %b want 1", ready); end
    step();
    idle_inputs();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h109 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL aw_header: got v=%b d=%h l=%b want v=1 d=109 l=0", out_valid, out_data, out_last); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h1234 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL aw_payload: got v=%b d=%h l=%b want v=1 d=1234 l=1", out_valid, out_data, out_last); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL aw_idle_after: got %b want 0", out_valid); end
    n_cmp++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL aw_pkt_cnt: got %0d want %0d", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_all_three();
    out_ready = 1'b1;
    drive(3'b111, 32'h1000, 36'hD_EADB_EEFF, 32'h2000, 5'b00111);
    step();
    idle_inputs();
    n_cmp++; if (out_data !== 64'h23F || out_last !== 1'b0) begin
      n_fail++; $display("FAIL all_header: got d=%h l=%b want d=23f l=0", out_data, out_last); end
    step();
    n_cmp++; if (out_data !== 64'hEADBEEFF_00001000 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL all_beat0: got d=%h l=%b want d=eadbeeff00001000 l=0", out_data, out_last); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL all_ready_mid: got %b want 0", ready); end
    step();
    n_cmp++; if (out_data !== 64'h2000D || out_last !== 1'b1) begin
      n_fail++; $display("FAIL all_beat1: got d=%h l=%b want d=2000d l=1", out_data, out_last); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL all_end: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, pkt_cnt, exp_cnt); end
  endtask

  task automatic test_loge_only();
    out_ready = 1'b1;
    drive(3'b000, 32'h0, 36'h0, 32'h0, 5'b10000);
    step();
    idle_inputs();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h80 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL loge_header: got v=%b d=%h l=%b want v=1 d=80 l=1", out_valid, out_data, out_last); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL loge_end: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, pkt_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(3'b011, 32'hAAAA_5555, 36'h9_8765_4321, 32'h0, 5'b00010);
    step();
    idle_inputs();
    n_cmp++; if (out_data !== 64'h213) begin n_fail++; $display("FAIL bp_header: got %h want 213", out_data); end
    step();
    out_ready = 1'b0;
    drive(3'b100, 32'h0, 36'h0, 32'hFFFF_0000, 5'b11111);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h87654321_AAAA5555 || out_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=87654321aaaa5555 l=0", i, out_valid, out_data, out_last); end
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, ready); end
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    n_cmp++; if (out_data !== 64'h87654321_AAAA5555) begin n_fail++; $display("FAIL bp_resume0: got %h want 87654321aaaa5555", out_data); end
    step();
    n_cmp++; if (out_data !== 64'h9 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL bp_beat1: got d=%h l=%b want d=9 l=1", out_data, out_last); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL bp_end: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, pkt_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(3'b001, 32'h11, 36'h0, 32'h0, 5'b00000);
    step();
    idle_inputs();
    n_cmp++; if (out_data !== 64'h101) begin n_fail++; $display("FAIL b2b_hdr_a: got %h want 101", out_data); end
    step();
    drive(3'b000, 32'h0, 36'h0, 32'h0, 5'b00010);
    n_cmp++; if (ready !== 1'b1 || out_data !== 64'h11 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_last_a: got r=%b d=%h l=%b want r=1 d=11 l=1", ready, out_data, out_last); end
    step();
    idle_inputs();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h10 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hdr_b: got v=%b d=%h l=%b want v=1 d=10 l=1", out_valid, out_data, out_last); end
    n_cmp++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt_a: got %0d want %0d", pkt_cnt, exp_cnt); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL b2b_end: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, pkt_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b1;
    drive(3'b111, 32'h1000, 36'hD_EADB_EEFF, 32'h2000, 5'b00111);
    step();
    idle_inputs();
    step();
    n_cmp++; if (out_data !== 64'hEADBEEFF_00001000) begin n_fail++; $display("FAIL rmid_pay0: got %h want eadbeeff00001000", out_data); end
    rstn = 1'b0;
    #1;
    exp_cnt = 32'd0;
    n_cmp++; if (out_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort: got v=%b r=%b want v=0 r=0", out_valid, ready); end
    n_cmp++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", pkt_cnt); end
    step();
    rstn = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release_ready: got %b want 1", ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rmid_no_partial: got v=%b cnt=%0d want v=0 cnt=0", out_valid, pkt_cnt); end
    test_aw_only();
  endtask

  initial begin
    test_reset();
    test_aw_only();
    test_all_three();
    test_loge_only();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_log_packer.md
AXIL_LOG_PACKER -- requirements
Module: axil_log_packer

Interface
REQ-001 Parameter AW_WIDTH, 32, width of the AW log-body record (awaddr).
REQ-002 Parameter W_WIDTH, 36, width of the W log-body record {wdata, wstrb}.
REQ-003 Parameter AR_WIDTH, 32, width of the AR log-body record (araddr).
REQ-004 Port clk  in  1  sole clock; all logic is rising-edge.
REQ-005 Port rstn  in  1  reset; asynchronous assert, active-low.
REQ-006 Port logb_valid  in  3  per-channel log-body valid; bit0 AW, bit1 W, bit2 AR.
REQ-007 Port logb_data  in  AW_WIDTH+W_WIDTH+AR_WIDTH  packed bodies; AW at [31:0], W at [67:32], AR at [99:68].
REQ-008 Port loge_valid  in  5  per-channel log-end valid bits, passed through as a bitmap.
REQ-009 Port ready  out  1  shared accept for logb_valid/loge_valid, as seen by all recorder loggers.
REQ-010 Port out_valid  out  1  output stream beat valid.
REQ-011 Port out_data  out  64  output stream beat.
REQ-012 Port out_last  out  1  final beat of a packet.
REQ-013 Port out_ready  in  1  downstream accept.
REQ-014 Port pkt_cnt  out  32  count of packets fully emitted.

Function
REQ-015 A log transaction is accepted on a cycle with ready=1 and (|logb_valid || |loge_valid); the block samples all three input buses on that edge.
REQ-016 ready = rstn && (state==IDLE || (out_valid && out_ready && out_last)); combinational.
REQ-017 States: IDLE, HDR, PAY0, PAY1; IDLE->HDR on accept; HDR->PAY0 on beat handshake if beats>=1, else packet end; PAY0->PAY1 on handshake if beats==2, else packet end; PAY1 -> packet end on handshake.
REQ-018 Packet end with a simultaneous accept -> HDR (no bubble); packet end without accept -> IDLE.
REQ-019 Header beat: [2:0]=logb bitmap, [7:3]=loge bitmap, [15:8]=payload beat count, [63:16]=0.
REQ-020 Payload: bodies of channels whose logb bit is set, concatenated in index order (AW, W, AR), first present body at bit 0, contiguous, zero-padded to 64-bit multiple.
REQ-021 Beat count = ceil(sum of present widths / 64): none 0; any single 1; AW+AR 1; AW+W 2; W+AR 2; all 2.
REQ-022 out_valid=1 in HDR/PAY0/PAY1; out_data/out_last stable while out_valid && !out_ready.
REQ-023 out_last=1 on the header when beats==0, else on the final payload beat.
REQ-024 Latency: header presented the cycle after accept; one beat per cycle under continuous out_ready.
REQ-025 pkt_cnt increments by 1 on each last-beat handshake; wraps 0xFFFF_FFFF -> 0.
REQ-026 Inputs with ready=0 are ignored; no data loss because the loggers hold valid until ready.

Reset
REQ-027 rstn low: state=IDLE, out_valid=0, out_last=0, out_data=0, pkt_cnt=0, ready=0, captured registers cleared.
REQ-028 Reset asserted mid-packet aborts the packet immediately; no partial beat after release; pkt_cnt not incremented.
REQ-029 First cycle after release: ready=1, out_valid=0.

Verification
REQ-030 AW only, awaddr 0x1234, loge 5'b00001, out_ready=1 -> header 0x109, then payload 0x1234 with out_last; pkt_cnt=1.
REQ-031 All three: AW 0x1000, W 0xDEADBEEFF, AR 0x2000, loge 5'b00111 -> header 0x23F, beat0 0xEADBEEFF_00001000, beat1 0x2000D with out_last.
REQ-032 loge only 5'b10000 -> single beat 0x80 with out_last; no payload.
REQ-033 out_ready held 0 for 3 cycles on beat0 of a 2-beat packet -> beat0 stable, ready=0, new inputs not accepted; resumes on out_ready=1.
REQ-034 Back-to-back: next accept on last-beat handshake -> next header the following cycle, no idle cycle.
REQ-035 rstn pulsed low during PAY0 -> out_valid=0 at once; pkt_cnt=0; next packet after release is correct.
